// File: rtl/fb_pkg.sv
// Shared constants and FSM state type for the framebuffer scan-out block.
package fb_pkg;

  localparam int unsigned FB_DIM          = 64;
  localparam int unsigned PIX_PER_BEAT    = 8;
  localparam int unsigned BEATS_PER_ROW   = FB_DIM / PIX_PER_BEAT;
  localparam int unsigned BEATS_PER_FRAME = BEATS_PER_ROW * FB_DIM;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

endpackage

// File: rtl/popcount8.sv
// Combinational count of set bits in an 8-bit word.
module popcount8 (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, data_i[i]};
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Snapshots a 64x64 1-bpp frame and streams it out as 8-pixel beats in raster order,
// tracking the number of lit pixels actually accepted downstream.
module fb_scanout import fb_pkg::*; #(
  parameter int unsigned FB_DIM       = fb_pkg::FB_DIM,
  parameter int unsigned PIX_PER_BEAT = fb_pkg::PIX_PER_BEAT
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [FB_DIM*FB_DIM-1:0] frame_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [PIX_PER_BEAT-1:0]  out_data,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_eof,
  output logic                     busy,
  output logic                     done,
  output logic [12:0]              pix_count
);

  localparam int unsigned NumPix = FB_DIM * FB_DIM;

  state_e            state_q, state_d;
  logic [NumPix-1:0] snap_q, snap_d;
  logic [5:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic [12:0]       pix_q, pix_d;

  logic [11:0] base;
  logic [7:0]  raw;
  logic [7:0]  beat;
  logic [3:0]  ones;
  logic [13:0] sum;
  logic        xfer;
  logic        last_col;
  logic        last_beat;

  assign base = {row_q, col_q, 3'b000};
  assign raw  = snap_q[base +: 8];

  // Leftmost pixel (lowest x) goes out on the MSB.
  always_comb begin
    beat = 8'h00;
    for (int b = 0; b < 8; b++) begin
      beat[7-b] = raw[b];
    end
  end

  popcount8 u_popcount (
    .data_i  (beat),
    .count_o (ones)
  );

  assign out_valid = (state_q == StSend);
  assign busy      = out_valid;
  assign done      = (state_q == StDone);
  assign xfer      = out_valid && out_ready;
  assign last_col  = (col_q == 3'(BEATS_PER_ROW - 1));
  assign last_beat = ({row_q, col_q} == 9'(BEATS_PER_FRAME - 1));

  assign out_data  = out_valid ? beat : '0;
  assign out_sof   = out_valid && (row_q == 6'd0) && (col_q == 3'd0);
  assign out_eol   = out_valid && last_col;
  assign out_eof   = out_valid && last_beat;
  assign pix_count = pix_q;

  // Saturate at a full frame of lit pixels rather than wrapping.
  assign sum = {1'b0, pix_q} + {10'd0, ones};

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    pix_d   = pix_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d  = frame_in;
          row_d   = 6'd0;
          col_d   = 3'd0;
          pix_d   = 13'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          state_d = StIdle;
        end else if (xfer) begin
          pix_d = (sum > 14'(NumPix)) ? 13'(NumPix) : sum[12:0];
          col_d = col_q + 3'd1;
          if (last_col) begin
            row_d = row_q + 6'd1;
          end
          if (last_beat) begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      row_q   <= 6'd0;
      col_q   <= 3'd0;
      pix_q   <= 13'd0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Randomized bench for fb_scanout against a pixel-coordinate reference model.
module tb_fb_scanout;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          abort;
  logic [4095:0] frame_in;
  logic          out_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          done;
  logic [12:0]   pix_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fb_scanout #(
    .FB_DIM       (64),
    .PIX_PER_BEAT (8)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .abort     (abort),
    .frame_in  (frame_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pixel (x,y) lives at bit y*64+x; beat k covers y=k/8, x=8*(k%8)..+7, leftmost on bit 7.
  function automatic logic [7:0] exp_beat(input logic [4095:0] fr, input int k);
    logic [7:0] e;
    int y;
    int x0;
    y  = k / 8;
    x0 = (k % 8) * 8;
    e  = 8'h00;
    for (int b = 0; b < 8; b++) e[7-b] = fr[y*64 + x0 + b];
    return e;
  endfunction

  function automatic logic [4095:0] rand_frame();
    logic [4095:0] fr;
    for (int i = 0; i < 128; i++) fr[i*32 +: 32] = $urandom;
    return fr;
  endfunction

  // mode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic do_frame(input logic [4095:0] fr, input int mode, input int abort_at,
                          input int rst_at, input bit poke);
    int         k;
    int         cyc;
    int         exp_pix;
    int         n_sof;
    int         n_eol;
    int         n_eof;
    logic       rdy;
    logic [7:0] e;
    k = 0; cyc = 0; exp_pix = 0; n_sof = 0; n_eol = 0; n_eof = 0;
    @(negedge clk);
    frame_in  = fr;
    start     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("valid_rise", out_valid, 1);
    check("pix_clear", pix_count, 0);
    while (k < 512 && cyc < 4000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (poke) begin
        if (cyc == 20) frame_in = '1;
        start = (cyc == 30);
      end
      e = exp_beat(fr, k);
      check("valid", out_valid, 1);
      check("busy", busy, 1);
      check("done_low", done, 0);
      check("data", out_data, e);
      check("sof", out_sof, k == 0);
      check("eol", out_eol, k % 8 == 7);
      check("eof", out_eof, k == 511);
      if (k == abort_at) begin
        out_ready = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_pix", pix_count, exp_pix);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
          check("abort_idle", out_valid, 0);
          check("abort_hold", pix_count, exp_pix);
        end
        out_ready = 1'b0;
        return;
      end
      if (k == rst_at) begin
        out_ready = 1'b1;
        n_rst     = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        check("rst_marks", {out_sof, out_eol, out_eof}, 0);
        check("rst_pix", pix_count, 0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("rst_wait_idle", out_valid, 0);
        end
        out_ready = 1'b0;
        return;
      end
      out_ready = rdy;
      if (rdy) begin
        exp_pix += $countones(e);
        n_sof   += int'(out_sof);
        n_eol   += int'(out_eol);
        n_eof   += int'(out_eof);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("beats_sent", k, 512);
    check("done_pulse", done, 1);
    check("done_valid", out_valid, 0);
    check("pix_final", pix_count, exp_pix);
    check("pix_frame", pix_count, $countones(fr));
    check("n_sof", n_sof, 1);
    check("n_eol", n_eol, 64);
    check("n_eof", n_eof, 1);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    check("done_once", done, 0);
    check("no_restart", out_valid, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_done", done, 0);
      check("pix_hold", pix_count, exp_pix);
    end
  endtask

  initial begin
    logic [4095:0] fr;
    n_rst     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    frame_in  = '0;
    #12;
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data", out_data, 0);
    check("reset_pix", pix_count, 0);
    @(negedge clk);
    n_rst = 1'b1;
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check("idle_valid", out_valid, 0);

    fr = '0;
    for (int y = 0; y < 64; y++) fr[y*64 + y] = 1'b1;
    do_frame(fr, 0, -1, -1, 1'b0);
    do_frame('0, 0, -1, -1, 1'b0);
    do_frame('1, 0, -1, -1, 1'b0);
    do_frame(rand_frame(), 1, -1, -1, 1'b0);
    do_frame(rand_frame(), 0, -1, -1, 1'b1);
    do_frame(rand_frame(), 0, 100, -1, 1'b0);
    do_frame(rand_frame(), 2, -1, -1, 1'b0);
    do_frame(rand_frame(), 1, -1, 300, 1'b0);
    do_frame(rand_frame(), 0, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 SHALL have parameter FB_DIM, default 64, frame width and height in pixels; only 64 is supported.
REQ-002 SHALL have parameter PIX_PER_BEAT, default 8, pixels per output beat; only 8 is supported.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to scan out the current frame_in.
REQ-006 SHALL have port abort  input  1  synchronous cancel of an in-progress scan.
REQ-007 SHALL have port frame_in  input  4096  bitmap; pixel (x,y) = frame_in[y*64+x], 1 = lit.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the current beat.
REQ-009 SHALL have port out_valid  output  1  out_data and the markers hold a valid beat.
REQ-010 SHALL have port out_data  output  8  eight pixels of one row.
REQ-011 SHALL have port out_sof  output  1  current beat is the first of the frame.
REQ-012 SHALL have port out_eol  output  1  current beat is the last of a row.
REQ-013 SHALL have port out_eof  output  1  current beat is the last of the frame.
REQ-014 SHALL have port busy  output  1  scan in progress (state SEND).
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.
REQ-016 SHALL have port pix_count  output  13  number of lit pixels in accepted beats of the current or last frame.

Function
REQ-017 SHALL implement states IDLE, SEND and DONE.
REQ-018 IDLE: start=1 SHALL copy frame_in into an internal 4096-bit snapshot, clear the row/column counters and pix_count, and go to SEND.
REQ-019 out_valid SHALL rise in the cycle after start is sampled.
REQ-020 frame_in changes after capture SHALL have no effect on the frame being sent.
REQ-021 Ordering: beat k = row*8+col, with row 0..63 and col 0..7; 512 beats per frame, in raster order.
REQ-022 Packing: out_data[7-b] = snapshot pixel (x = 8*col+b, y = row), so bit 7 is the leftmost pixel.
REQ-023 Markers: out_sof = (row==0 && col==0), out_eol = (col==7), out_eof = (row==63 && col==7); all are gated by out_valid.
REQ-024 Handshake: a beat transfers when out_valid && out_ready in the same cycle.
REQ-025 While out_valid && !out_ready, out_data and the markers SHALL be held stable.
REQ-026 On each transfer, col SHALL increment; when col wraps 7->0, row SHALL increment.
REQ-027 On each transfer, pix_count SHALL add the popcount of out_data.
REQ-028 pix_count SHALL be 13-bit unsigned, with a maximum of 4096; it SHALL NOT wrap.
REQ-029 When the out_eof beat transfers, the FSM SHALL go to DONE and out_valid SHALL be 0 in the following cycle.
REQ-030 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-031 pix_count SHALL hold its final value until the next accepted start.
REQ-032 start SHALL be ignored in SEND and in DONE.
REQ-033 A new start is accepted only in IDLE, so the earliest new frame begins 2 cycles after the last handshake.
REQ-034 abort=1 in SEND SHALL force IDLE on the next edge: out_valid=0, no done pulse, pix_count holds its partial value.
REQ-035 abort has priority over a simultaneous transfer; that beat SHALL NOT be counted.
REQ-036 abort SHALL be ignored outside SEND.
REQ-037 busy SHALL be 1 exactly while the state is SEND.
REQ-038 There SHALL be no combinational path from out_ready to out_valid.

Reset
REQ-039 n_rst=0 SHALL immediately force state IDLE and out_valid, out_sof, out_eol, out_eof, busy and done all 0.
REQ-040 n_rst=0 SHALL also clear out_data, pix_count, the row/column counters and the snapshot to 0.
REQ-041 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait in IDLE for start.

Structure
REQ-042 Package fb_pkg SHALL hold FB_DIM, PIX_PER_BEAT, BEATS_PER_ROW (8), BEATS_PER_FRAME (512) and the state enum type.
REQ-043 The 8-bit popcount SHALL be a sub-module popcount8 (8-bit in, 4-bit out, combinational).

Verification
REQ-044 Diagonal frame (bits y*64+y set), out_ready=1:
- 512 beats; row r carries 8'h80>>(r%8) at col r/8 and 0 elsewhere.
- pix_count=64; done pulses 1 cycle after the eof beat.
REQ-045 Empty frame, then all-ones frame:
- Empty: 512 beats of 8'h00, pix_count=0.
- All-ones: 512 beats of 8'hFF, pix_count=4096.
REQ-046 Backpressure: out_ready pattern 1,0,0,1 repeating:
- out_data and markers are stable across stall cycles.
- Beat order is unchanged; sof, eol and eof each appear on the correct beat once.
REQ-047 Snapshot and ignored start: alter frame_in to all-ones and pulse start during SEND:
- Output still matches the captured frame.
- No restart occurs; exactly one done pulse.
REQ-048 abort at beat 100: out_valid=0 on the next cycle, no done pulse, pix_count frozen; a later start sends a full 512-beat frame.
REQ-049 Reset mid-frame: n_rst low at beat 300 gives immediate zero outputs and IDLE; a fresh start produces a correct full frame.
